// File: rtl/z80_bus_pkg.sv
// Shared types and default constants for the Z80 bus arbiter slice.
//   arb_state_t : arbiter FSM encoding (IDLE, REQ, GRANT, RELEASE, GAP)
//   DEF_*       : default parameter values for the arbiter and wait generator
package z80_bus_pkg;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    GRANT,
    RELEASE,
    GAP
  } arb_state_t;

  localparam int unsigned DEF_MAX_HOLD = 64;
  localparam int unsigned DEF_CPU_GAP  = 8;
  localparam int unsigned DEF_MEM_WAIT = 2;
  localparam int unsigned DEF_IO_WAIT  = 1;
  localparam int unsigned DEF_CW       = 8;

endpackage

// File: rtl/z80_wait_gen.sv
// nWAIT generator for CPU memory / IO cycles that target slow devices.
//   clk, rst_n : clock, asynchronous active-low reset
//   mreq_n, iorq_n, rd_n, wr_n, rfsh_n, m1_n : Z80 control strobes
//   mem_slow   : current memory cycle targets a slow device
//   wait_n     : registered wait request, low for the programmed cycle count
module z80_wait_gen
  import z80_bus_pkg::*;
#(
  parameter int unsigned MEM_WAIT = DEF_MEM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic clk,
  input  logic rst_n,
  input  logic mreq_n,
  input  logic iorq_n,
  input  logic rd_n,
  input  logic wr_n,
  input  logic rfsh_n,
  input  logic m1_n,
  input  logic mem_slow,
  output logic wait_n
);

  logic          mem_act;
  logic          io_act;
  logic          mem_q;
  logic          io_q;
  logic          mem_start;
  logic          io_start;
  logic [CW-1:0] load;
  logic [CW-1:0] cnt;

  // Refresh cycles never assert nRD/nWR with nRFSH high, and interrupt
  // acknowledge drives nIORQ together with nM1, so both fall out here.
  assign mem_act   = ~mreq_n & rfsh_n & (~rd_n | ~wr_n);
  assign io_act    = ~iorq_n & m1_n;
  assign mem_start = mem_act & ~mem_q;
  assign io_start  = io_act & ~io_q;
  assign load      = mem_start ? (mem_slow ? CW'(MEM_WAIT) : '0) : CW'(IO_WAIT);

  // cnt holds the number of low cycles still owed after the current one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q  <= 1'b0;
      io_q   <= 1'b0;
      cnt    <= '0;
      wait_n <= 1'b1;
    end else begin
      mem_q <= mem_act;
      io_q  <= io_act;
      if (mem_start || io_start) begin
        if (load != '0) begin
          wait_n <= 1'b0;
          cnt    <= load - 1'b1;
        end else begin
          wait_n <= 1'b1;
          cnt    <= '0;
        end
      end else if (mreq_n && iorq_n) begin
        wait_n <= 1'b1;
        cnt    <= '0;
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end else begin
        wait_n <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/z80_bus_arbiter.sv
// Shares the Z80 bus between the CPU and one secondary master via nBUSRQ/nBUSACK,
// with a bounded DMA tenure and a minimum CPU gap between tenures; also drives nWAIT.
//   CLK, nRESET : clock, asynchronous active-low reset
//   nBUSRQ      : bus request to CPU (registered, active low)
//   nBUSACK     : bus acknowledge from CPU (async, two-flop synchronised)
//   dma_req     : secondary master wants the bus (level)
//   dma_gnt     : secondary master owns the bus (registered)
//   nMREQ, nIORQ, nRD, nWR, nRFSH, nM1, mem_slow : CPU cycle decode for waits
//   nWAIT       : wait request to CPU, forced high while the CPU is off the bus
module z80_bus_arbiter
  import z80_bus_pkg::*;
#(
  parameter int unsigned MAX_HOLD = DEF_MAX_HOLD,
  parameter int unsigned CPU_GAP  = DEF_CPU_GAP,
  parameter int unsigned MEM_WAIT = DEF_MEM_WAIT,
  parameter int unsigned IO_WAIT  = DEF_IO_WAIT,
  parameter int unsigned CW       = DEF_CW
) (
  input  logic CLK,
  input  logic nRESET,
  output logic nBUSRQ,
  input  logic nBUSACK,
  input  logic dma_req,
  output logic dma_gnt,
  input  logic nMREQ,
  input  logic nIORQ,
  input  logic nRD,
  input  logic nWR,
  input  logic nRFSH,
  input  logic nM1,
  input  logic mem_slow,
  output logic nWAIT
);

  logic          ack_s1;
  logic          ack_s2;
  logic          ack;
  arb_state_t    state;
  logic [CW-1:0] hold;
  logic [CW-1:0] gap;
  logic          gen_wait_n;

  assign ack = ~ack_s2;

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      ack_s1  <= 1'b1;
      ack_s2  <= 1'b1;
      state   <= IDLE;
      nBUSRQ  <= 1'b1;
      dma_gnt <= 1'b0;
      hold    <= '0;
      gap     <= '0;
    end else begin
      ack_s1 <= nBUSACK;
      ack_s2 <= ack_s1;
      case (state)
        IDLE: begin
          if (dma_req) begin
            state  <= REQ;
            nBUSRQ <= 1'b0;
          end
        end
        REQ: begin
          // ack wins over a simultaneous dma_req drop: one GRANT cycle follows.
          if (ack) begin
            state   <= GRANT;
            dma_gnt <= 1'b1;
            hold    <= '0;
          end else if (!dma_req) begin
            state  <= RELEASE;
            nBUSRQ <= 1'b1;
          end
        end
        GRANT: begin
          // Losing ack here is a CPU protocol error; dropping the grant keeps
          // the secondary master off a bus it no longer owns.
          if (!dma_req || !ack ||
              (MAX_HOLD != 0 && hold == CW'(MAX_HOLD - 1))) begin
            state   <= RELEASE;
            dma_gnt <= 1'b0;
            nBUSRQ  <= 1'b1;
          end else begin
            hold <= hold + 1'b1;
          end
        end
        RELEASE: begin
          if (!ack) begin
            if (CPU_GAP == 0) begin
              state <= IDLE;
            end else begin
              state <= GAP;
              gap   <= '0;
            end
          end
        end
        GAP: begin
          if (gap == CW'(CPU_GAP - 1)) begin
            state <= IDLE;
          end else begin
            gap <= gap + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  z80_wait_gen #(
    .MEM_WAIT (MEM_WAIT),
    .IO_WAIT  (IO_WAIT),
    .CW       (CW)
  ) u_wait_gen (
    .clk      (CLK),
    .rst_n    (nRESET),
    .mreq_n   (nMREQ),
    .iorq_n   (nIORQ),
    .rd_n     (nRD),
    .wr_n     (nWR),
    .rfsh_n   (nRFSH),
    .m1_n     (nM1),
    .mem_slow (mem_slow),
    .wait_n   (gen_wait_n)
  );

  assign nWAIT = gen_wait_n | (state == GRANT) | (state == RELEASE);

endmodule

// File: tb/tb_z80_bus_arbiter.sv
// Directed bench for z80_bus_arbiter: tenure latency, hold limit, CPU gap,
// aborted request, wait generation, async reset and a random ownership sweep.
module tb_z80_bus_arbiter;
  import z80_bus_pkg::*;

  localparam int unsigned MAX_HOLD = 4;
  localparam int unsigned CPU_GAP  = 8;

  logic CLK;
  logic nRESET;
  logic nBUSRQ;
  logic nBUSACK;
  logic dma_req;
  logic dma_gnt;
  logic nMREQ;
  logic nIORQ;
  logic nRD;
  logic nWR;
  logic nRFSH;
  logic nM1;
  logic mem_slow;
  logic nWAIT;

  int unsigned ack_dly;
  int n_checks;
  int n_pass;

  z80_bus_arbiter #(
    .MAX_HOLD (MAX_HOLD),
    .CPU_GAP  (CPU_GAP),
    .MEM_WAIT (2),
    .IO_WAIT  (1),
    .CW       (8)
  ) dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .nBUSRQ   (nBUSRQ),
    .nBUSACK  (nBUSACK),
    .dma_req  (dma_req),
    .dma_gnt  (dma_gnt),
    .nMREQ    (nMREQ),
    .nIORQ    (nIORQ),
    .nRD      (nRD),
    .nWR      (nWR),
    .nRFSH    (nRFSH),
    .nM1      (nM1),
    .mem_slow (mem_slow),
    .nWAIT    (nWAIT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // CPU bus model: nBUSACK follows nBUSRQ on the (ack_dly+1)-th falling
  // clock edge after they start to differ.
  initial begin
    int unsigned pend;
    pend = 0;
    forever begin
      @(negedge CLK);
      if (nBUSRQ !== nBUSACK) begin
        if (pend >= ack_dly) begin
          nBUSACK = nBUSRQ;
          pend    = 0;
        end else begin
          pend++;
        end
      end else begin
        pend = 0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int g;
    g = 0;
    while (dut.state != IDLE && g < 100) begin
      tick();
      g++;
    end
    check(tag, 32'(dut.state == IDLE), 1);
  endtask

  task automatic wait_gnt(input string tag);
    int g;
    g = 0;
    while (!dma_gnt && g < 100) begin
      tick();
      g++;
    end
    check(tag, 32'(dma_gnt), 1);
  endtask

  // Runs one CPU cycle for 'cycles' clocks, then idles 3 clocks; counts
  // every sampled nWAIT-low cycle across the whole window.
  task automatic cpu_cycle(input string tag, input logic mreq_n, input logic iorq_n,
                           input logic rd_n, input logic wr_n, input logic rfsh_n,
                           input logic m1_n, input logic slow, input int unsigned cycles,
                           input int unsigned exp);
    int unsigned lows;
    lows = 0;
    tick();
    nMREQ = mreq_n; nIORQ = iorq_n; nRD = rd_n; nWR = wr_n;
    nRFSH = rfsh_n; nM1 = m1_n; mem_slow = slow;
    repeat (cycles) begin
      tick();
      if (!nWAIT) lows++;
    end
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    nRFSH = 1'b1; nM1 = 1'b1; mem_slow = 1'b0;
    repeat (3) begin
      tick();
      if (!nWAIT) lows++;
    end
    check(tag, lows, exp);
  endtask

  initial begin
    int g;
    int unsigned cnt;
    int unsigned viol;
    int unsigned grants;
    logic gnt_seen;
    logic gnt_prev;

    n_checks = 0;
    n_pass   = 0;
    ack_dly  = 1;
    nRESET   = 1'b0;
    nBUSACK  = 1'b1;
    dma_req  = 1'b0;
    nMREQ = 1'b1; nIORQ = 1'b1; nRD = 1'b1; nWR = 1'b1;
    nRFSH = 1'b1; nM1 = 1'b1; mem_slow = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_busrq", 32'(nBUSRQ), 1);
    check("rst_gnt",   32'(dma_gnt), 0);
    check("rst_wait",  32'(nWAIT), 1);
    check("rst_state", 32'(dut.state == IDLE), 1);
    @(negedge CLK);
    nRESET = 1'b1;
    tick();

    // 1: basic tenure
    dma_req = 1'b1;
    tick();
    check("t1_busrq_lat", 32'(nBUSRQ), 0);
    g = 0;
    while (nBUSACK && g < 50) begin
      tick();
      g++;
    end
    check("t1_ack_seen", 32'(nBUSACK), 0);
    // this sample sits just after the first edge following nBUSACK falling
    cnt = 1;
    while (!dma_gnt && cnt < 20) begin
      tick();
      cnt++;
    end
    check("t1_gnt_lat", cnt, 3);
    tick();
    check("t1_gnt_held", 32'(dma_gnt), 1);
    check("t1_busrq_held", 32'(nBUSRQ), 0);
    dma_req = 1'b0;
    tick();
    check("t1_gnt_drop", 32'(dma_gnt), 0);
    check("t1_busrq_drop", 32'(nBUSRQ), 1);
    wait_idle("t1_idle");

    // 2: tenure limit and CPU gap
    dma_req = 1'b1;
    wait_gnt("t2_gnt");
    cnt = 0;
    while (dma_gnt && cnt < 20) begin
      cnt++;
      tick();
    end
    check("t2_hold_len", cnt, MAX_HOLD);
    check("t2_busrq_rel", 32'(nBUSRQ), 1);
    g = 0;
    while (!nBUSACK && g < 50) begin
      tick();
      g++;
    end
    check("t2_ack_back", 32'(nBUSACK), 1);
    // 2 sync edges + RELEASE->GAP + CPU_GAP gap cycles + IDLE->REQ
    cnt = 1;
    while (nBUSRQ && cnt < 50) begin
      tick();
      cnt++;
    end
    check("t2_gap_len", cnt, CPU_GAP + 4);
    dma_req = 1'b0;
    wait_idle("t2_idle");

    // 3: aborted request
    gnt_seen = 1'b0;
    dma_req = 1'b1;
    tick();
    check("t3_busrq_low", 32'(nBUSRQ), 0);
    dma_req = 1'b0;
    tick();
    check("t3_busrq_high", 32'(nBUSRQ), 1);
    tick();
    check("t3_gap", 32'(dut.state == GAP), 1);
    g = 0;
    while (dut.state != IDLE && g < 100) begin
      gnt_seen = gnt_seen | dma_gnt;
      tick();
      g++;
    end
    check("t3_idle", 32'(dut.state == IDLE), 1);
    check("t3_no_gnt", 32'(gnt_seen), 0);

    // 4: wait generation (nMREQ, nIORQ, nRD, nWR, nRFSH, nM1, slow)
    cpu_cycle("t4_slow_rd",  0, 1, 0, 1, 1, 1, 1, 6, 2);
    cpu_cycle("t4_fast_rd",  0, 1, 0, 1, 1, 1, 0, 6, 0);
    cpu_cycle("t4_slow_wr",  0, 1, 1, 0, 1, 1, 1, 6, 2);
    cpu_cycle("t4_io_wr",    1, 0, 1, 0, 1, 1, 0, 6, 1);
    cpu_cycle("t4_refresh",  0, 1, 1, 1, 0, 0, 1, 6, 0);
    cpu_cycle("t4_intack",   1, 0, 1, 1, 1, 0, 0, 6, 0);
    cpu_cycle("t4_abort",    0, 1, 0, 1, 1, 1, 1, 1, 1);
    // waits are masked while the DMA master holds the bus
    dma_req = 1'b1;
    wait_gnt("t4_mask_gnt");
    cpu_cycle("t4_masked",   0, 1, 0, 1, 1, 1, 1, 2, 0);
    dma_req = 1'b0;
    wait_idle("t4_idle");

    // 5: async reset mid-GRANT
    dma_req = 1'b1;
    wait_gnt("t5_gnt");
    #3;
    nRESET = 1'b0;
    #1;
    check("t5_gnt_async", 32'(dma_gnt), 0);
    check("t5_busrq_async", 32'(nBUSRQ), 1);
    @(negedge CLK);
    dma_req = 1'b0;
    nRESET  = 1'b1;
    tick();
    check("t5_idle", 32'(dut.state == IDLE), 1);
    check("t5_busrq_idle", 32'(nBUSRQ), 1);
    g = 0;
    while (!nBUSACK && g < 50) begin
      tick();
      g++;
    end
    check("t5_ack_back", 32'(nBUSACK), 1);
    repeat (3) tick();

    // 6: random ownership sweep
    viol     = 0;
    grants   = 0;
    gnt_prev = 1'b0;
    for (int i = 0; i < 10000; i++) begin
      tick();
      if (dma_gnt && (dut.ack_s2 || nBUSACK)) viol++;
      if (dma_gnt && !gnt_prev) grants++;
      gnt_prev = dma_gnt;
      if ($urandom_range(0, 15) == 0) dma_req = ~dma_req;
      if ($urandom_range(0, 7) == 0) ack_dly = $urandom_range(0, 4);
    end
    check("t6_ownership", viol, 0);
    check("t6_activity", 32'(grants > 10), 1);
    dma_req = 1'b0;
    ack_dly = 1;
    wait_idle("t6_idle");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
